multicycle_decoder: RTL
=======================

Name: multicycle_decoder

Overview:
- Control unit for the multicycle ARM-subset datapath: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several cycles on a shared memory port.
- Generalises the single-cycle decoder:
  - wider ALU control (adds EOR);
  - parametrised memory wait states;
  - per-state write strobes gated by the condition check;
  - illegal-instruction reporting.
- Sits between the instruction register / condition-check unit and the datapath muxes, register file, memory and PC register.

Parameters:
- ALUCTRL_W, 3, width of alu_control; must be >= 3; upper bits zero-extended.
- MEM_WAIT, 0, extra wait cycles per memory access (0..15); applies in FETCH, MEMREAD and MEMWRITE.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20].
- rd  in  4  instr[15:12].
- cond_ex  in  1  condition passed (from the condition unit); sampled combinationally.
- pc_write  out  1  PC register enable.
- ir_write  out  1  instruction register enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register-file write enable.
- adr_src  out  1  0 = PC, 1 = ALU result as memory address.
- alu_src_a  out  1  0 = register A, 1 = PC.
- alu_src_b  out  2  00 = register, 01 = extended immediate, 10 = constant 4.
- result_src  out  2  00 = ALU out register, 01 = read data, 10 = ALU direct.
- imm_src  out  2  equals op.
- reg_src  out  2  [0] = op==10, [1] = op==01 & ~funct[0].
- alu_control  out  ALUCTRL_W  operation code.
- flag_w  out  2  [1] = write N/Z, [0] = write C/V.
- illegal  out  1  one-cycle pulse on an unimplemented instruction.

Behaviour:
- Reset:
  - Synchronous, active-high; state <= FETCH, wait counter <= 0.
  - While reset is high, all strobes (pc_write, ir_write, mem_write, reg_write, flag_w, illegal) are 0.
  - alu_control is ADD (0) during reset.
  - Reset mid-instruction aborts it; nothing is written.
- Wait counter: in FETCH, MEMREAD and MEMWRITE the FSM stays MEM_WAIT extra cycles. "Last" means counter == MEM_WAIT; the counter clears on state exit.
- FETCH:
  - adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10.
  - ir_write=1 and pc_write=1 on the last cycle only.
  - Then -> DECODE.
- DECODE:
  - alu_src_a=1, alu_src_b=10, result_src=10; no strobes.
  - op=00: funct[5] ? EXECUTEI : EXECUTER.
  - op=01: MEMADR.
  - op=10: BRANCH.
  - op=11: FETCH with illegal=1 that cycle.
- EXECUTER:
  - alu_src_a=0, alu_src_b=00, ALU decode active.
  - flag_w: [1] = funct[0] & cond_ex; [0] = [1] & (ADD or SUB).
  - Then -> ALUWB.
- EXECUTEI: as EXECUTER but alu_src_b=01.
- ALU decode on funct[4:1]:
  - 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 0001 EOR=4.
  - Any other code: alu_control=0, flag_w=0, illegal=1 in the execute cycle, FSM -> FETCH, no writeback.
- ALUWB:
  - result_src=00, reg_write=cond_ex.
  - If rd==1111, also pc_write=cond_ex.
  - Then -> FETCH.
- MEMADR:
  - alu_src_a=0, alu_src_b=01, ADD.
  - funct[0] ? MEMREAD : MEMWRITE.
- MEMREAD:
  - adr_src=1, result_src=00.
  - Last cycle -> MEMWB.
- MEMWB:
  - result_src=01, reg_write=cond_ex; pc_write=cond_ex if rd==1111.
  - Then -> FETCH.
- MEMWRITE:
  - adr_src=1.
  - mem_write=cond_ex on the last cycle only.
  - Then -> FETCH.
- BRANCH:
  - alu_src_a=0, alu_src_b=01, ADD, result_src=10.
  - pc_write=cond_ex.
  - Then -> FETCH.
- Defaults:
  - Every strobe not listed for a state is 0.
  - alu_control=0 outside the execute states.
  - imm_src and reg_src are combinational from op in all states.
- Latency at MEM_WAIT=0:
  - data-processing 4 cycles;
  - LDR 5;
  - STR 4;
  - B 3.
  - Each memory access adds MEM_WAIT cycles.
- Condition false (cond_ex=0): the state sequence is unchanged; all architectural write strobes except FETCH's are suppressed.

Optional Feature:
- DECODER_CMP_EN defined:
  - funct[4:1]=1010 (CMP) decodes to SUB; 1000 (TST) decodes to AND.
  - For both, funct[0] must be 1. The execute state asserts flag_w, then -> FETCH directly, skipping ALUWB (no reg_write).
  - CMP/TST with funct[0]=0: illegal.
- Undefined: 1010 and 1000 are illegal, as above.

Test Plan:
- Reset held 2 cycles, then released -> state FETCH, all strobes 0 during reset; ir_write=1 and pc_write=1 in first cycle after release (MEM_WAIT=0).
- ADD: op=00, funct=101001, rd=0011, cond_ex=1 -> EXECUTEI: alu_control=0, flag_w=11; ALUWB: reg_write=1, pc_write=0; 4 cycles total.
- ORR: op=00, funct=011000, rd=1111, cond_ex=1 -> alu_control=3, flag_w=00; ALUWB asserts reg_write and pc_write.
- MEM_WAIT=2, LDR: op=01, funct=011001, cond_ex=1 -> FETCH 3 cycles, MEMREAD 3 cycles, MEMWB reg_write=1; 9 cycles total.
- STR with cond_ex=0 -> mem_write never asserted; FSM returns to FETCH after 4 cycles. B with cond_ex=0 -> pc_write=0 in BRANCH.
- op=11 -> illegal=1 for exactly one cycle in DECODE, then FETCH. EOR (funct[4:1]=0001) -> alu_control=4.

Source files
------------

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: Moore-style control FSM for the multicycle ARM-subset
// datapath. It sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK over a
// shared memory port, with MEM_WAIT extra cycles on every memory access.
// Optional build macro: DECODER_CMP_EN adds CMP (SUB) and TST (AND), which
// only write flags and skip register writeback.
module multicycle_decoder #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_WAIT  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           op,
    input  logic [5:0]           funct,
    input  logic [3:0]           rd,
    input  logic                 cond_ex,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 adr_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [1:0]           imm_src,
    output logic [1:0]           reg_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           flag_w,
    output logic                 illegal
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_BRANCH
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4
    } alu_op_e;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       mem_state;
    logic       mem_last;

    alu_op_e    dec_op;
    logic       dec_ok;
    logic       dec_nowb;
    logic       dec_arith;
    logic       flag_nz;
    alu_op_e    alu_op;

    // Immediate and register-source selects follow the opcode in every state.
    assign imm_src    = op;
    assign reg_src[0] = (op == 2'b10);
    assign reg_src[1] = (op == 2'b01) & ~funct[0];

    // Memory-access states dwell until the wait counter reaches MEM_WAIT.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE);
    assign mem_last  = (wait_q == 4'(MEM_WAIT));
    assign wait_d    = (mem_state && !mem_last) ? wait_q + 4'd1 : 4'd0;

    // ALU operation decode from funct[4:1]; unknown codes are flagged illegal.
    always_comb begin
        dec_op   = ALU_ADD;
        dec_ok   = 1'b0;
        dec_nowb = 1'b0;
        case (funct[4:1])
            4'b0100: begin dec_op = ALU_ADD; dec_ok = 1'b1; end
            4'b0010: begin dec_op = ALU_SUB; dec_ok = 1'b1; end
            4'b0000: begin dec_op = ALU_AND; dec_ok = 1'b1; end
            4'b1100: begin dec_op = ALU_ORR; dec_ok = 1'b1; end
            4'b0001: begin dec_op = ALU_EOR; dec_ok = 1'b1; end
`ifdef DECODER_CMP_EN
            // Compare/test only make sense when they set flags (S bit).
            4'b1010: begin dec_op = ALU_SUB; dec_ok = funct[0]; dec_nowb = 1'b1; end
            4'b1000: begin dec_op = ALU_AND; dec_ok = funct[0]; dec_nowb = 1'b1; end
`endif
            default: begin dec_op = ALU_ADD; dec_ok = 1'b0; end
        endcase
    end

    assign dec_arith = (dec_op == ALU_ADD) || (dec_op == ALU_SUB);
    assign flag_nz   = funct[0] & cond_ex;

    // Next-state and output decode for the current state.
    always_comb begin
        // NOTE: every output and next-state gets a default up front so no path
        // through the case statement leaves a signal unassigned (no latches).
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        flag_w     = 2'b00;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b = (state_q == S_EXECUTEI) ? 2'b01 : 2'b00;
                if (dec_ok) begin
                    alu_op    = dec_op;
                    flag_w[1] = flag_nz;
                    flag_w[0] = flag_nz & dec_arith;
                    state_d   = dec_nowb ? S_FETCH : S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ALUWB: begin
                reg_write = cond_ex;
                pc_write  = cond_ex & (rd == 4'b1111);
                state_d   = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_last) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
                pc_write   = cond_ex & (rd == 4'b1111);
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                if (mem_last) begin
                    mem_write = cond_ex;
                    state_d   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every strobe so an aborted instruction writes nothing.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
            flag_w    = 2'b00;
            alu_op    = ALU_ADD;
        end
    end

    assign alu_control = ALUCTRL_W'(alu_op);

    // State register and memory wait counter with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule
